// File: rtl/port_io_responder.sv
// Port-mapped I/O responder for the kcpsmx port bus: DATA/STATUS/TIMER/CONTROL registers,
// inbound and outbound byte FIFOs bridging to valid/ready streams, and an interval timer.
module port_io_responder #(
    parameter logic [7:0] BASE_ADDR  = 8'h00,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic [7:0] ext_in_data,
    input  logic       ext_in_valid,
    output logic       ext_in_ready,
    output logic [7:0] ext_out_data,
    output logic       ext_out_valid,
    input  logic       ext_out_ready
);
    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    r_in_mem [FIFO_DEPTH];
    logic [AW-1:0] r_in_rd, r_in_wr;
    logic [AW:0]   r_in_cnt;
    logic [7:0]    r_out_mem [FIFO_DEPTH];
    logic [AW-1:0] r_out_rd, r_out_wr;
    logic [AW:0]   r_out_cnt;
    logic [7:0]    r_in_port, r_reload, r_count;
    logic          r_interrupt, r_ext_in_ready, r_flag, r_ovf, r_udf;
    logic [2:0]    r_ctrl;

    logic [7:0]    w_off, w_rd_data;
    logic          w_hit, w_sel_data, w_sel_status, w_sel_timer, w_sel_ctrl;
    logic          w_in_empty, w_in_push, w_in_pop, w_in_udf;
    logic          w_out_valid, w_out_full, w_out_wr, w_out_pop, w_out_push, w_out_ovf;
    logic          w_expire, w_stat_rd, w_cause;
    logic [AW:0]   w_in_cnt_nxt, w_out_cnt_nxt;

    // Address decode is relative to BASE_ADDR so the block can sit anywhere in port space.
    assign w_off        = port_id - BASE_ADDR;
    assign w_hit        = (w_off[7:2] == 6'd0);
    assign w_sel_data   = w_hit & (w_off[1:0] == 2'd0);
    assign w_sel_status = w_hit & (w_off[1:0] == 2'd1);
    assign w_sel_timer  = w_hit & (w_off[1:0] == 2'd2);
    assign w_sel_ctrl   = w_hit & (w_off[1:0] == 2'd3);

    assign w_in_empty   = (r_in_cnt == '0);
    assign w_in_push    = ext_in_valid & r_ext_in_ready;
    assign w_in_pop     = read_strobe & w_sel_data & ~w_in_empty;
    assign w_in_udf     = read_strobe & w_sel_data & w_in_empty;
    assign w_in_cnt_nxt = r_in_cnt + {{AW{1'b0}}, w_in_push} - {{AW{1'b0}}, w_in_pop};

    // A push into a full OUT FIFO survives only if the head leaves in the same cycle.
    assign w_out_valid   = (r_out_cnt != '0);
    assign w_out_full    = (r_out_cnt == DEPTH_C);
    assign w_out_wr      = write_strobe & w_sel_data;
    assign w_out_pop     = w_out_valid & ext_out_ready;
    assign w_out_push    = w_out_wr & (~w_out_full | w_out_pop);
    assign w_out_ovf     = w_out_wr & w_out_full & ~w_out_pop;
    assign w_out_cnt_nxt = r_out_cnt + {{AW{1'b0}}, w_out_push} - {{AW{1'b0}}, w_out_pop};

    assign w_expire  = r_ctrl[2] & (r_count == 8'd0);
    assign w_stat_rd = read_strobe & w_sel_status;
    assign w_cause   = (r_ctrl[0] & ~w_in_empty) | (r_ctrl[1] & r_flag);

    always_comb begin
        w_rd_data = 8'h00;
        if (w_sel_data)   w_rd_data = w_in_empty ? 8'h00 : r_in_mem[r_in_rd];
        if (w_sel_status) w_rd_data = {3'b000, r_udf, r_ovf, r_flag, w_out_full, ~w_in_empty};
        if (w_sel_timer)  w_rd_data = r_count;
        if (w_sel_ctrl)   w_rd_data = {5'b00000, r_ctrl};
    end

    always_ff @(posedge clk) begin
        if (w_in_push)  r_in_mem[r_in_wr]   <= ext_in_data;
        if (w_out_push) r_out_mem[r_out_wr] <= out_port;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_rd        <= '0;
            r_in_wr        <= '0;
            r_in_cnt       <= '0;
            r_out_rd       <= '0;
            r_out_wr       <= '0;
            r_out_cnt      <= '0;
            r_in_port      <= 8'h00;
            r_interrupt    <= 1'b0;
            r_ext_in_ready <= 1'b0;
            r_reload       <= 8'h00;
            r_count        <= 8'h00;
            r_flag         <= 1'b0;
            r_ovf          <= 1'b0;
            r_udf          <= 1'b0;
            r_ctrl         <= 3'b000;
        end else begin
            if (w_in_push)  r_in_wr  <= r_in_wr + AW'(1);
            if (w_in_pop)   r_in_rd  <= r_in_rd + AW'(1);
            if (w_out_push) r_out_wr <= r_out_wr + AW'(1);
            if (w_out_pop)  r_out_rd <= r_out_rd + AW'(1);
            r_in_cnt       <= w_in_cnt_nxt;
            r_out_cnt      <= w_out_cnt_nxt;
            r_ext_in_ready <= (w_in_cnt_nxt != DEPTH_C);
            r_in_port      <= w_rd_data;
            r_interrupt    <= w_cause & ~interrupt_ack;

            if (write_strobe & w_sel_timer) begin
                r_reload <= out_port;
                r_count  <= out_port;
            end else if (r_ctrl[2]) begin
                r_count <= w_expire ? r_reload : r_count - 8'd1;
            end
            if (write_strobe & w_sel_ctrl) r_ctrl <= out_port[2:0];

            // Setting beats clearing so an expiry coinciding with a clear is not lost.
            if (w_expire)                        r_flag <= 1'b1;
            else if (w_stat_rd | interrupt_ack)  r_flag <= 1'b0;
            if (w_out_ovf)      r_ovf <= 1'b1;
            else if (w_stat_rd) r_ovf <= 1'b0;
            if (w_in_udf)       r_udf <= 1'b1;
            else if (w_stat_rd) r_udf <= 1'b0;
        end
    end

    assign in_port       = r_in_port;
    assign interrupt     = r_interrupt;
    assign ext_in_ready  = r_ext_in_ready;
    assign ext_out_valid = w_out_valid;
    assign ext_out_data  = w_out_valid ? r_out_mem[r_out_rd] : 8'h00;

endmodule
